// File: rtl/rv32i_types.sv
// ============================================================================
//  Module   : rv32i_types (package)
//  Brief    : Shared types for the instruction/data memory arbiter: word and
//             mask types, grant encoding and arbiter FSM state encoding.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv32i_types;

    typedef logic [31:0] rv32i_word;
    typedef logic [3:0]  rv32i_mem_wmask;

    // Which requester owns the shared port
    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2
    } arb_state_t;

    // Reads always present a full-word mask on the shared port
    localparam rv32i_mem_wmask C_READ_MASK = 4'b1111;

endpackage

`default_nettype wire

// File: rtl/mem_req_latch.sv
// ============================================================================
//  Module   : mem_req_latch
//  Brief    : Holds the granted request (address, write data, mask and
//             read/write strobes) stable on the shared memory port until the
//             transaction completes. Asynchronous active-low clear.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_req_latch
    import rv32i_types::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           i_load,
    input  logic           i_done,
    input  rv32i_word      i_address,
    input  rv32i_word      i_wdata,
    input  rv32i_mem_wmask i_mask,
    input  logic           i_read,
    input  logic           i_write,
    output rv32i_word      o_address,
    output rv32i_word      o_wdata,
    output rv32i_mem_wmask o_mask,
    output logic           o_read,
    output logic           o_write
);

    rv32i_word      r_address;
    rv32i_word      r_wdata;
    rv32i_mem_wmask r_mask;
    logic           r_read;
    logic           r_write;

    // Capture the request on grant; drop only the strobes on completion so the
    // address/data lines stay quiet between transactions.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_address <= '0;
            r_wdata   <= '0;
            r_mask    <= C_READ_MASK;
            r_read    <= 1'b0;
            r_write   <= 1'b0;
        end else if (i_load) begin
            r_address <= i_address;
            r_wdata   <= i_wdata;
            r_mask    <= i_mask;
            r_read    <= i_read;
            r_write   <= i_write;
        end else if (i_done) begin
            r_read    <= 1'b0;
            r_write   <= 1'b0;
        end
    end

    assign o_address = r_address;
    assign o_wdata   = r_wdata;
    assign o_mask    = r_mask;
    assign o_read    = r_read;
    assign o_write   = r_write;

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
//  Module   : mem_arbiter
//  Brief    : Two-requester (instruction / data) arbiter onto a single shared
//             memory port. One transaction at a time, registered port outputs,
//             optional round-robin fairness under contention.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter
    import rv32i_types::*;
#(
    parameter bit FAIR = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    // Instruction side
    input  logic           i_read,
    input  rv32i_word      i_address,
    output rv32i_word      i_rdata,
    output logic           i_resp,
    // Data side
    input  logic           d_read,
    input  logic           d_write,
    input  rv32i_word      d_address,
    input  rv32i_word      d_wdata,
    input  rv32i_mem_wmask d_byte_enable,
    output rv32i_word      d_rdata,
    output logic           d_resp,
    // Shared memory port
    output logic           mem_read,
    output logic           mem_write,
    output rv32i_word      mem_address,
    output rv32i_word      mem_wdata,
    output rv32i_mem_wmask mem_byte_enable,
    input  rv32i_word      mem_rdata,
    input  logic           mem_resp
);

    arb_state_t     r_state;
    arb_state_t     w_next_state;
    grant_t         r_last_grant;
    grant_t         w_grant;
    logic           w_load;
    logic           w_done;
    logic           w_i_req;
    logic           w_d_req;

    rv32i_word      r_i_rdata;
    rv32i_word      r_d_rdata;

    rv32i_word      w_ld_address;
    rv32i_word      w_ld_wdata;
    rv32i_mem_wmask w_ld_mask;
    logic           w_ld_read;
    logic           w_ld_write;

    assign w_i_req = i_read;
    assign w_d_req = d_read | d_write;

    // State, fairness history and last-read-data registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_last_grant <= GRANT_I;
            r_i_rdata    <= '0;
            r_d_rdata    <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_load) begin
                r_last_grant <= w_grant;
            end
            if (i_resp) begin
                r_i_rdata <= mem_rdata;
            end
            if (d_resp) begin
                r_d_rdata <= mem_rdata;
            end
        end
    end

    // Next-state and grant decision; only IDLE can start a transaction, so a
    // request still held during the response cycle waits one IDLE cycle.
    always_comb begin
        w_next_state = r_state;
        w_grant      = r_last_grant;
        w_load       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_i_req && w_d_req) begin
                    // Contention: data wins unless fairness hands it to the
                    // side that did not get the previous grant.
                    if (!FAIR || (r_last_grant == GRANT_I)) begin
                        w_grant = GRANT_D;
                    end else begin
                        w_grant = GRANT_I;
                    end
                    w_load = 1'b1;
                end else if (w_d_req) begin
                    w_grant = GRANT_D;
                    w_load  = 1'b1;
                end else if (w_i_req) begin
                    w_grant = GRANT_I;
                    w_load  = 1'b1;
                end
                if (w_load) begin
                    w_next_state = (w_grant == GRANT_D) ? D_BUSY : I_BUSY;
                end
            end
            I_BUSY, D_BUSY: begin
                if (mem_resp) begin
                    w_done       = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Request fields presented to the latch; simultaneous read+write on the
    // data side is treated as a write.
    assign w_ld_write   = (w_grant == GRANT_D) && d_write;
    assign w_ld_read    = (w_grant == GRANT_D) ? !d_write : 1'b1;
    assign w_ld_address = (w_grant == GRANT_D) ? d_address : i_address;
    assign w_ld_wdata   = (w_grant == GRANT_D) ? d_wdata : '0;
    assign w_ld_mask    = w_ld_write ? d_byte_enable : C_READ_MASK;

    mem_req_latch u_req_latch (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_load),
        .i_done    (w_done),
        .i_address (w_ld_address),
        .i_wdata   (w_ld_wdata),
        .i_mask    (w_ld_mask),
        .i_read    (w_ld_read),
        .i_write   (w_ld_write),
        .o_address (mem_address),
        .o_wdata   (mem_wdata),
        .o_mask    (mem_byte_enable),
        .o_read    (mem_read),
        .o_write   (mem_write)
    );

    // Completion is passed through in the same cycle, only to the owner
    assign i_resp  = (r_state == I_BUSY) && mem_resp;
    assign d_resp  = (r_state == D_BUSY) && mem_resp;
    assign i_rdata = i_resp ? mem_rdata : r_i_rdata;
    assign d_rdata = d_resp ? mem_rdata : r_d_rdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
//  Module   : tb_mem_arbiter
//  Brief    : Directed self-checking bench for mem_arbiter. A fair instance
//             and a data-priority instance share the requester inputs; each
//             has its own memory response line.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        i_read;
    logic [31:0] i_address;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_address;
    logic [31:0] d_wdata;
    logic [3:0]  d_byte_enable;
    logic [31:0] mem_rdata;
    logic        mem_resp;
    logic        n_mem_resp;

    logic [31:0] i_rdata, d_rdata, mem_address, mem_wdata;
    logic        i_resp, d_resp, mem_read, mem_write;
    logic [3:0]  mem_byte_enable;

    logic [31:0] n_i_rdata, n_d_rdata, n_mem_address, n_mem_wdata;
    logic        n_i_resp, n_d_resp, n_mem_read, n_mem_write;
    logic [3:0]  n_mem_byte_enable;

    int checks   = 0;
    int failures = 0;

    mem_arbiter #(.FAIR(1'b1)) u_dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_byte_enable(d_byte_enable), .d_rdata(d_rdata), .d_resp(d_resp),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    mem_arbiter #(.FAIR(1'b0)) u_dut_nf (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_address(i_address), .i_rdata(n_i_rdata), .i_resp(n_i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_byte_enable(d_byte_enable), .d_rdata(n_d_rdata), .d_resp(n_d_resp),
        .mem_read(n_mem_read), .mem_write(n_mem_write), .mem_address(n_mem_address),
        .mem_wdata(n_mem_wdata), .mem_byte_enable(n_mem_byte_enable),
        .mem_rdata(mem_rdata), .mem_resp(n_mem_resp)
    );

    // 10 time-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Step to just after the next rising edge (input drive point)
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Step to the falling edge (sample point)
    task automatic mid();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        i_read        = 1'b0;
        i_address     = 32'h0;
        d_read        = 1'b0;
        d_write       = 1'b0;
        d_address     = 32'h0;
        d_wdata       = 32'h0;
        d_byte_enable = 4'h0;
        mem_rdata     = 32'h0;
        mem_resp      = 1'b0;
        n_mem_resp    = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_inputs();
        cyc();
        cyc();
        rst = 1'b1;
    endtask

    // Asynchronous reset clears outputs without waiting for a clock edge
    task automatic test_reset();
        do_reset();
        i_read    = 1'b1;
        i_address = 32'h60;
        cyc();
        mid();
        checks++; if (mem_read !== 1'b1) begin failures++; $display("FAIL rst_pre_mem_read got=%b exp=1", mem_read); end
        cyc();
        #2 rst = 1'b0;
        #1;
        checks++; if (mem_read !== 1'b0) begin failures++; $display("FAIL rst_mem_read got=%b exp=0", mem_read); end
        checks++; if (mem_write !== 1'b0) begin failures++; $display("FAIL rst_mem_write got=%b exp=0", mem_write); end
        checks++; if (mem_address !== 32'h0) begin failures++; $display("FAIL rst_mem_address got=%h exp=0", mem_address); end
        checks++; if (mem_wdata !== 32'h0) begin failures++; $display("FAIL rst_mem_wdata got=%h exp=0", mem_wdata); end
        checks++; if (mem_byte_enable !== 4'b1111) begin failures++; $display("FAIL rst_mem_byte_enable got=%b exp=1111", mem_byte_enable); end
        checks++; if (i_resp !== 1'b0 || d_resp !== 1'b0) begin failures++; $display("FAIL rst_resp got=%b%b exp=00", i_resp, d_resp); end
        i_read = 1'b0;
        cyc();
        rst = 1'b1;
    endtask

    // Single instruction read: grant one cycle after request, resp at cycle 4
    task automatic test_i_read();
        do_reset();
        i_read    = 1'b1;
        i_address = 32'h60;
        for (int c = 1; c <= 5; c++) begin
            cyc();
            mem_resp  = (c == 4);
            mem_rdata = (c == 4) ? 32'h0000_0013 : 32'hFFFF_FFFF;
            if (c == 5) i_read = 1'b0;
            mid();
            checks++; if (mem_read !== (c <= 4)) begin failures++; $display("FAIL ird_mem_read c%0d got=%b exp=%b", c, mem_read, (c <= 4)); end
            checks++; if (i_resp !== (c == 4)) begin failures++; $display("FAIL ird_i_resp c%0d got=%b exp=%b", c, i_resp, (c == 4)); end
            checks++; if (d_resp !== 1'b0) begin failures++; $display("FAIL ird_d_resp c%0d got=%b exp=0", c, d_resp); end
            if (c <= 4) begin
                checks++; if (mem_address !== 32'h60) begin failures++; $display("FAIL ird_mem_address c%0d got=%h exp=60", c, mem_address); end
                checks++; if (mem_byte_enable !== 4'b1111) begin failures++; $display("FAIL ird_mask c%0d got=%b exp=1111", c, mem_byte_enable); end
            end
            if (c >= 4) begin
                checks++; if (i_rdata !== 32'h13) begin failures++; $display("FAIL ird_i_rdata c%0d got=%h exp=13", c, i_rdata); end
            end
        end
        mem_resp = 1'b0;
    endtask

    // Data write held stable despite requester input changes mid-transaction
    task automatic test_d_write();
        int n_dresp;
        int n_iresp;
        n_dresp = 0;
        n_iresp = 0;
        do_reset();
        d_write       = 1'b1;
        d_address     = 32'h100;
        d_wdata       = 32'hDEAD_BEEF;
        d_byte_enable = 4'b0011;
        for (int c = 1; c <= 5; c++) begin
            cyc();
            mem_resp = (c == 3);
            if (c == 2) begin
                d_address     = 32'h999;
                d_wdata       = 32'h0;
                d_byte_enable = 4'b1000;
            end
            if (c == 4) d_write = 1'b0;
            mid();
            if (d_resp === 1'b1) n_dresp++;
            if (i_resp === 1'b1) n_iresp++;
            checks++; if (mem_write !== (c <= 3)) begin failures++; $display("FAIL dwr_mem_write c%0d got=%b exp=%b", c, mem_write, (c <= 3)); end
            checks++; if (mem_read !== 1'b0) begin failures++; $display("FAIL dwr_mem_read c%0d got=%b exp=0", c, mem_read); end
            if (c <= 3) begin
                checks++; if (mem_address !== 32'h100 || mem_wdata !== 32'hDEAD_BEEF || mem_byte_enable !== 4'b0011) begin
                    failures++; $display("FAIL dwr_fields c%0d got=%h/%h/%b exp=100/deadbeef/0011", c, mem_address, mem_wdata, mem_byte_enable);
                end
            end
        end
        checks++; if (n_dresp != 1) begin failures++; $display("FAIL dwr_d_resp_count got=%0d exp=1", n_dresp); end
        checks++; if (n_iresp != 0) begin failures++; $display("FAIL dwr_i_resp_count got=%0d exp=0", n_iresp); end
        mem_resp = 1'b0;
    endtask

    // Fair instance under continuous contention: D, I, D, I with idle gaps
    task automatic test_fair();
        logic exp_d;
        do_reset();
        i_read    = 1'b1;
        i_address = 32'h40;
        d_read    = 1'b1;
        d_address = 32'h80;
        for (int g = 0; g < 4; g++) begin
            exp_d = (g % 2 == 0);
            cyc();
            mid();
            checks++; if (mem_read !== 1'b1 || mem_address !== (exp_d ? 32'h80 : 32'h40)) begin
                failures++; $display("FAIL fair_grant g%0d got=%b/%h exp=1/%h", g, mem_read, mem_address, (exp_d ? 32'h80 : 32'h40));
            end
            cyc();
            mem_resp  = 1'b1;
            mem_rdata = 32'h1000 + g;
            mid();
            checks++; if (d_resp !== exp_d || i_resp !== !exp_d) begin
                failures++; $display("FAIL fair_resp g%0d got=d%b i%b exp=d%b i%b", g, d_resp, i_resp, exp_d, !exp_d);
            end
            checks++; if ((exp_d ? d_rdata : i_rdata) !== 32'h1000 + g) begin
                failures++; $display("FAIL fair_rdata g%0d got=%h exp=%h", g, (exp_d ? d_rdata : i_rdata), 32'h1000 + g);
            end
            cyc();
            mem_resp = 1'b0;
            mid();
            checks++; if (mem_read !== 1'b0) begin failures++; $display("FAIL fair_gap g%0d got=%b exp=0", g, mem_read); end
        end
        clear_inputs();
    endtask

    // Data-priority instance: D served repeatedly, I only once D drops
    task automatic test_unfair();
        logic exp_d;
        do_reset();
        i_read    = 1'b1;
        i_address = 32'h40;
        d_read    = 1'b1;
        d_address = 32'h80;
        for (int g = 0; g < 4; g++) begin
            exp_d = (g < 3);
            cyc();
            mid();
            checks++; if (n_mem_read !== 1'b1 || n_mem_address !== (exp_d ? 32'h80 : 32'h40)) begin
                failures++; $display("FAIL nf_grant g%0d got=%b/%h exp=1/%h", g, n_mem_read, n_mem_address, (exp_d ? 32'h80 : 32'h40));
            end
            cyc();
            n_mem_resp = 1'b1;
            mid();
            checks++; if (n_d_resp !== exp_d || n_i_resp !== !exp_d) begin
                failures++; $display("FAIL nf_resp g%0d got=d%b i%b exp=d%b i%b", g, n_d_resp, n_i_resp, exp_d, !exp_d);
            end
            cyc();
            n_mem_resp = 1'b0;
            if (g == 2) d_read = 1'b0;
            mid();
            checks++; if (n_mem_read !== 1'b0) begin failures++; $display("FAIL nf_gap g%0d got=%b exp=0", g, n_mem_read); end
        end
        clear_inputs();
    endtask

    // mem_resp while idle produces nothing and leaves the FSM in IDLE
    task automatic test_idle_resp();
        do_reset();
        cyc();
        mem_resp = 1'b1;
        mid();
        checks++; if (i_resp !== 1'b0 || d_resp !== 1'b0) begin failures++; $display("FAIL idle_resp got=i%b d%b exp=0 0", i_resp, d_resp); end
        cyc();
        mem_resp  = 1'b0;
        i_read    = 1'b1;
        i_address = 32'h44;
        mid();
        checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin failures++; $display("FAIL idle_strobe got=%b%b exp=00", mem_read, mem_write); end
        cyc();
        mid();
        checks++; if (mem_read !== 1'b1 || mem_address !== 32'h44) begin failures++; $display("FAIL idle_then_grant got=%b/%h exp=1/44", mem_read, mem_address); end
        clear_inputs();
    endtask

    // Reset during a data write aborts it and restores last_grant to I
    task automatic test_reset_mid();
        do_reset();
        d_write       = 1'b1;
        d_address     = 32'h200;
        d_wdata       = 32'hCAFE_F00D;
        d_byte_enable = 4'b1100;
        cyc();
        mid();
        checks++; if (mem_write !== 1'b1) begin failures++; $display("FAIL rmid_pre_write got=%b exp=1", mem_write); end
        cyc();
        rst      = 1'b0;
        mem_resp = 1'b1;
        #1;
        checks++; if (mem_write !== 1'b0) begin failures++; $display("FAIL rmid_mem_write got=%b exp=0", mem_write); end
        checks++; if (d_resp !== 1'b0) begin failures++; $display("FAIL rmid_d_resp got=%b exp=0", d_resp); end
        cyc();
        mem_resp  = 1'b0;
        rst       = 1'b1;
        i_read    = 1'b1;
        i_address = 32'h48;
        mid();
        checks++; if (mem_write !== 1'b0 || mem_read !== 1'b0) begin failures++; $display("FAIL rmid_idle got=%b%b exp=00", mem_read, mem_write); end
        cyc();
        mid();
        checks++; if (mem_write !== 1'b1 || mem_address !== 32'h200 || mem_byte_enable !== 4'b1100) begin
            failures++; $display("FAIL rmid_regrant got=%b/%h/%b exp=1/200/1100", mem_write, mem_address, mem_byte_enable);
        end
        clear_inputs();
    endtask

    // Safety net so the run always terminates
    initial begin
        #100000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // Test sequence
    initial begin
        rst = 1'b0;
        clear_inputs();
        test_reset();
        test_i_read();
        test_d_write();
        test_fair();
        test_unfair();
        test_idle_resp();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
